// File: rtl/alarm_ring_sequencer.sv
// Alarm ring/snooze sequencer: detects the alarm time, rings with a 1 s beep
// pattern, handles snooze/dismiss and times out, all paced by a 1 Hz tick.
module alarm_ring_sequencer #(
   parameter int unsigned RING_TIMEOUT   = 60,
   parameter int unsigned SNOOZE_SECONDS = 300,
   parameter int unsigned MAX_SNOOZES    = 3
) (
   input  logic        i_Clk,
   input  logic        i_Reset_n,
   input  logic        i_Tick,
   input  logic        i_Alarm_Enable,
   input  logic        i_Snooze,
   input  logic        i_Dismiss,
   input  logic [31:0] i_Time,
   input  logic [31:0] i_Alarm_Time,
   output logic        o_Alarm_On,
   output logic        o_Buzzer,
   output logic        o_Snooze_Active,
   output logic [1:0]  o_Snooze_Count,
   output logic [8:0]  o_Seconds_Left,
   output logic [1:0]  o_State
);

   localparam int unsigned SECS_W  = 9;
   localparam int unsigned COUNT_W = 2;

   localparam logic [SECS_W-1:0]  RING_LOAD   = SECS_W'(RING_TIMEOUT);
   localparam logic [SECS_W-1:0]  SNOOZE_LOAD = SECS_W'(SNOOZE_SECONDS);
   localparam logic [COUNT_W-1:0] COUNT_MAX   = COUNT_W'(MAX_SNOOZES);

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RINGING = 2'd2,
      ST_SNOOZE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [SECS_W-1:0]    secs_q, secs_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 phase_q, phase_d;
   logic                 match_d_q;
   logic                 match;
   logic                 trig;

   assign match = (i_Time == i_Alarm_Time);
   assign trig  = match & ~match_d_q;

   // State and datapath registers
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q   <= ST_OFF;
         secs_q    <= '0;
         count_q   <= '0;
         phase_q   <= 1'b0;
         match_d_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         secs_q    <= secs_d;
         count_q   <= count_d;
         phase_q   <= phase_d;
         match_d_q <= match;
      end
   end

   // Next-state: disable > dismiss > snooze > trig / tick expiry
   always_comb begin
      state_d = state_q;
      secs_d  = secs_q;
      count_d = count_q;
      phase_d = phase_q;
      case (state_q)
         ST_OFF: begin
            secs_d  = '0;
            count_d = '0;
            phase_d = 1'b0;
            if (i_Alarm_Enable) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!i_Alarm_Enable) begin
               state_d = ST_OFF;
            end else if (trig) begin
               state_d = ST_RINGING;
               secs_d  = RING_LOAD;
               phase_d = 1'b1;
            end
         end
         ST_RINGING: begin
            if (!i_Alarm_Enable || i_Dismiss) begin
               state_d = i_Alarm_Enable ? ST_ARMED : ST_OFF;
               secs_d  = '0;
               count_d = '0;
               phase_d = 1'b0;
            end else if (i_Snooze && (count_q < COUNT_MAX)) begin
               state_d = ST_SNOOZE;
               secs_d  = SNOOZE_LOAD;
               count_d = count_q + COUNT_W'(1);
               phase_d = 1'b0;
            end else if (i_Tick) begin
               if (secs_q <= SECS_W'(1)) begin
                  state_d = ST_ARMED;
                  secs_d  = '0;
                  count_d = '0;
                  phase_d = 1'b0;
               end else begin
                  secs_d  = secs_q - SECS_W'(1);
                  phase_d = ~phase_q;
               end
            end
         end
         ST_SNOOZE: begin
            if (!i_Alarm_Enable || i_Dismiss) begin
               state_d = i_Alarm_Enable ? ST_ARMED : ST_OFF;
               secs_d  = '0;
               count_d = '0;
               phase_d = 1'b0;
            end else if (i_Tick) begin
               if (secs_q <= SECS_W'(1)) begin
                  state_d = ST_RINGING;
                  secs_d  = RING_LOAD;
                  phase_d = 1'b1;
               end else begin
                  secs_d  = secs_q - SECS_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_OFF;
            secs_d  = '0;
            count_d = '0;
            phase_d = 1'b0;
         end
      endcase
   end

   // Outputs decode registered state only
   assign o_State         = state_q;
   assign o_Alarm_On      = (state_q == ST_RINGING);
   assign o_Buzzer        = (state_q == ST_RINGING) & phase_q;
   assign o_Snooze_Active = (state_q == ST_SNOOZE);
   assign o_Snooze_Count  = count_q;
   assign o_Seconds_Left  = secs_q;

endmodule

// File: tb/tb_alarm_ring_sequencer.sv
// Directed bench for alarm_ring_sequencer: expected outputs are queued as each
// step is driven and compared after the sampling edge.
module tb_alarm_ring_sequencer;

   typedef struct packed {
      logic [1:0] st;
      logic       on;
      logic       bz;
      logic       sa;
      logic [1:0] cnt;
      logic [8:0] secs;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick, en, snooze, dismiss;
   logic [31:0] tm, at;
   logic        alarm_on, buzzer, snooze_active;
   logic [1:0]  snooze_count, state;
   logic [8:0]  seconds_left;

   int checks = 0;
   int errors = 0;
   obs_t  sb_q[$];
   string tag_q[$];

   localparam logic [31:0] ALARM = 32'h0006_3000;
   localparam logic [31:0] AWAY  = 32'h0006_3001;

   alarm_ring_sequencer #(
      .RING_TIMEOUT(4),
      .SNOOZE_SECONDS(5),
      .MAX_SNOOZES(2)
   ) dut (
      .i_Clk(clk),
      .i_Reset_n(rst_n),
      .i_Tick(tick),
      .i_Alarm_Enable(en),
      .i_Snooze(snooze),
      .i_Dismiss(dismiss),
      .i_Time(tm),
      .i_Alarm_Time(at),
      .o_Alarm_On(alarm_on),
      .o_Buzzer(buzzer),
      .o_Snooze_Active(snooze_active),
      .o_Snooze_Count(snooze_count),
      .o_Seconds_Left(seconds_left),
      .o_State(state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic obs_t ex(input int st, input int on, input int bz,
                               input int sa, input int cnt, input int secs);
      ex = {2'(st), 1'(on), 1'(bz), 1'(sa), 2'(cnt), 9'(secs)};
   endfunction

   task automatic compare_head();
      obs_t  o, e;
      string t;
      o = {state, alarm_on, buzzer, snooze_active, snooze_count, seconds_left};
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
   endtask

   task automatic check_now(input string tag, input obs_t exp);
      sb_q.push_back(exp);
      tag_q.push_back(tag);
      compare_head();
   endtask

   task automatic step(input string tag, input obs_t exp);
      sb_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      compare_head();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
      tm = 32'h0006_2959; at = ALARM;
      #3;
      check_now("reset_state", ex(0,0,0,0,0,0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("off_idle", ex(0,0,0,0,0,0));

      // Arm and time out
      en = 1'b1;
      step("arm", ex(1,0,0,0,0,0));
      tm = ALARM;
      step("ring_entry", ex(2,1,1,0,0,4));
      step("ring_hold", ex(2,1,1,0,0,4));
      tick = 1'b1;
      step("tick1", ex(2,1,0,0,0,3));
      step("tick2", ex(2,1,1,0,0,2));
      step("tick3", ex(2,1,0,0,0,1));
      step("timeout", ex(1,0,0,0,0,0));
      tick = 1'b0;
      step("no_retrig_held", ex(1,0,0,0,0,0));

      // Snooze limit; entry tick not counted
      tm = AWAY;
      step("away", ex(1,0,0,0,0,0));
      tm = ALARM; tick = 1'b1;
      step("ring_entry_tick", ex(2,1,1,0,0,4));
      tick = 1'b0; snooze = 1'b1;
      step("snooze1", ex(3,0,0,1,1,5));
      snooze = 1'b0; tick = 1'b1;
      step("snz_t1", ex(3,0,0,1,1,4));
      tick = 1'b0; snooze = 1'b1;
      step("snz_snooze_ignored", ex(3,0,0,1,1,4));
      snooze = 1'b0; tick = 1'b1;
      for (int i = 2; i <= 4; i++) step("snz_tick", ex(3,0,0,1,1,5-i));
      step("snz_expire", ex(2,1,1,0,1,4));
      tick = 1'b0; snooze = 1'b1;
      step("snooze2", ex(3,0,0,1,2,5));
      snooze = 1'b0; tick = 1'b1;
      for (int i = 1; i <= 4; i++) step("snz2_tick", ex(3,0,0,1,2,5-i));
      step("snz2_expire", ex(2,1,1,0,2,4));
      tick = 1'b0; snooze = 1'b1;
      step("snooze3_ignored", ex(2,1,1,0,2,4));

      // Dismiss beats snooze
      dismiss = 1'b1;
      step("dismiss_wins", ex(1,0,0,0,0,0));
      snooze = 1'b0; dismiss = 1'b0;

      // Disable mid-snooze
      tm = AWAY;
      step("away2", ex(1,0,0,0,0,0));
      tm = ALARM;
      step("ring2", ex(2,1,1,0,0,4));
      snooze = 1'b1;
      step("snooze_a", ex(3,0,0,1,1,5));
      snooze = 1'b0; tick = 1'b1;
      step("snooze_a_t1", ex(3,0,0,1,1,4));
      step("snooze_a_t2", ex(3,0,0,1,1,3));
      tick = 1'b0; en = 1'b0;
      step("disable_mid_snooze", ex(0,0,0,0,0,0));

      // Enable while match already high
      step("off_at_match", ex(0,0,0,0,0,0));
      en = 1'b1;
      step("enable_at_match", ex(1,0,0,0,0,0));
      step("no_ring_at_enable", ex(1,0,0,0,0,0));
      tm = AWAY;
      step("edit_away", ex(1,0,0,0,0,0));
      tm = ALARM;
      step("edit_back_rings", ex(2,1,1,0,0,4));

      // Async reset mid-ring
      #2; rst_n = 1'b0;
      #1;
      check_now("async_reset", ex(0,0,0,0,0,0));
      #2; rst_n = 1'b1; en = 1'b0;
      step("post_reset_off", ex(0,0,0,0,0,0));
      step("post_reset_off2", ex(0,0,0,0,0,0));
      en = 1'b1;
      step("rearm_no_resume", ex(1,0,0,0,0,0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_ring_sequencer.md
# alarm_ring_sequencer

Sequences the alarm after it is armed: it detects the alarm time, rings, handles snooze and dismiss, and times out automatically. It sits between the time/alarm counters and the buzzer/LED outputs, replacing a simple on/off alarm flag with a full ring/snooze schedule. A 1 Hz tick drives all timing; the time-setting path and the display path are not affected.

## Interface
- RING_TIMEOUT, 60: ticks a ring lasts before it auto-stops; range 1..511
- SNOOZE_SECONDS, 300: ticks a snooze lasts; range 1..511
- MAX_SNOOZES, 3: snoozes allowed per alarm event; range 0..3

- i_Clk  in  1  system clock
- i_Reset_n  in  1  asynchronous active-low reset
- i_Tick  in  1  one-cycle 1 Hz strobe
- i_Alarm_Enable  in  1  level; alarm switch
- i_Snooze  in  1  one-cycle pulse (debounced button)
- i_Dismiss  in  1  one-cycle pulse (debounced button)
- i_Time  in  32  current time, BCD digits
- i_Alarm_Time  in  32  alarm time, BCD digits
- o_Alarm_On  out  1  high in RINGING
- o_Buzzer  out  1  beep pattern
- o_Snooze_Active  out  1  high in SNOOZE
- o_Snooze_Count  out  2  snoozes used in the current event
- o_Seconds_Left  out  9  value of the active ring or snooze counter; 0 otherwise
- o_State  out  2  OFF=0, ARMED=1, RINGING=2, SNOOZE=3

## Operation
- Match detection:
  - match = (i_Time == i_Alarm_Time).
  - r_Match_d is a register that updates every cycle, in every state.
  - trig = match & ~r_Match_d, a rising edge only.
- State transitions. Priority, highest first: ~i_Alarm_Enable > i_Dismiss > i_Snooze > trig / counter expiry.
  - OFF: i_Alarm_Enable=1 -> ARMED.
  - ARMED:
    - enable low -> OFF.
    - trig -> RINGING; load counter with RING_TIMEOUT; set phase=1.
  - RINGING:
    - enable low -> OFF; clear count.
    - i_Dismiss -> ARMED; clear count.
    - i_Snooze with count<MAX_SNOOZES -> SNOOZE; load SNOOZE_SECONDS; count+1.
    - i_Snooze with count==MAX_SNOOZES is ignored.
    - i_Tick: counter-1 and phase toggles. If counter==1 when the tick arrives -> ARMED (timeout); clear count.
  - SNOOZE:
    - enable low -> OFF; clear count.
    - i_Dismiss -> ARMED; clear count.
    - i_Tick: counter-1. If counter==1 when the tick arrives -> RINGING; reload RING_TIMEOUT; phase=1.
    - i_Snooze is ignored.
- Counter behaviour:
  - A ring or snooze lasts exactly N ticks after entry.
  - A tick arriving in the same cycle as entry is not counted.
  - The counter is 9-bit unsigned and never wraps. It is 0 in OFF and ARMED.
- Outputs:
  - o_Buzzer = (state==RINGING) & phase.
  - All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- Boundary cases:
  - Enabling while match is already high does not ring; a rising edge is required.
  - A time edit that lands on the alarm time does ring.
  - Dismiss and snooze in the same cycle: dismiss wins.
  - A trig while in RINGING or SNOOZE is ignored.

## Timing
- Reset (asynchronous, i_Reset_n=0):
  - state=OFF, counter=0, count=0, phase=0, r_Match_d=0.
  - All outputs 0.
- Release of reset is synchronous to the next i_Clk rising edge.
- Latencies:
  - Enable high at edge k -> o_State=ARMED after edge k.
  - Match rising edge sampled at edge k -> o_Alarm_On=1 and o_Buzzer=1 after edge k (1-cycle latency).
  - Snooze, dismiss and disable take effect after the sampling edge (1-cycle latency).
- Sustained ring: the buzzer is high for 1 s and low for 1 s alternately. The first high second starts at ring entry.
- Reset asserted mid-ring or mid-snooze returns immediately to OFF with all outputs 0. It does not resume after release.

## Test plan
Unless noted, parameters are RING_TIMEOUT=4, SNOOZE_SECONDS=5, MAX_SNOOZES=2.
- Arm and time out: enable=1; i_Time steps to equal i_Alarm_Time=0x00063000.
  - o_Alarm_On=1 one cycle later; o_Seconds_Left=4.
  - o_Buzzer over the ticks is 1,0,1,0.
  - After the 4th tick: o_State=1, o_Alarm_On=0, o_Snooze_Count=0.
- Snooze limit: ring, then snooze -> o_Snooze_Active=1, o_Seconds_Left=5.
  - After 5 ticks: RINGING, o_Seconds_Left=4.
  - Snooze again -> count=2.
  - A third snooze in the following ring is ignored; state stays 2.
- Dismiss priority: during RINGING, pulse i_Snooze and i_Dismiss in the same cycle -> o_State=1, o_Snooze_Count=0.
- Enable-at-match: hold i_Time==i_Alarm_Time, raise enable -> ARMED, no ring.
  - Change i_Time away and back to the alarm time -> rings.
- Disable mid-snooze: drop enable during SNOOZE with o_Seconds_Left=3 -> o_State=0, all outputs 0 next cycle.
- Async reset: pulse i_Reset_n low for 3 ns between clock edges during RINGING -> all outputs 0 immediately.
  - After release the block stays in OFF until enable is sampled high.
